sw_debounce: RTL and testbench



---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/sw_debounce_chan.sv | 70 +++++++
 rtl/sw_debounce.sv | 50 +++++
 tb/tb_sw_debounce.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared defaults and helpers for the slide-switch debouncer.
package sw_debounce_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_PRESCALE_BITS = 16;
  localparam int DEF_STABLE_TICKS  = 4;
  localparam int SYNC_DEPTH        = 2;

  // Counter width able to hold 0..stable_ticks.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: two-flop synchronizer, tick-timed stability filter,
// registered rise/fall strobes.
module sw_debounce_chan
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw_in,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W    = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  db_q, db_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  s2;

  assign s2 = sync_q[SYNC_DEPTH-1];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    sync_d = {sync_q[SYNC_DEPTH-2:0], sw_in};
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2 == db_q) begin
      cnt_d = '0;
    end else if (tick && cnt_q == CNT_LAST) begin
      // Flip on the qualifying tick; the strobe lands on the same edge as the level.
      db_d   = s2;
      cnt_d  = '0;
      rise_d = s2;
      fall_d = ~s2;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: reset is sampled on the clock edge only; all state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: shared prescaler tick feeding WIDTH independent
// debounce channels.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
  parameter int STABLE_TICKS  = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             tick
);

  logic [PRESCALE_BITS-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q + PRESCALE_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Decoded from the counter, so it is low while the prescaler sits in reset.
  assign tick = &presc_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sw_debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .sw_in(sw[i]),
      .db   (sw_db[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: edge-level reference model plus
// directed latency/strobe scenarios and randomized bounce.
module tb_sw_debounce;

  localparam int W   = 8;
  localparam int PB  = 2;
  localparam int ST  = 3;
  localparam int PER = 1 << PB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] sw_db, sw_rise, sw_fall;
  logic         tick;

  sw_debounce #(
    .WIDTH(W),
    .PRESCALE_BITS(PB),
    .STABLE_TICKS(ST)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: n counts edges since reset release; a tick is seen at
  // edge n when n mod 2^P is the last value; the filter sees sw from two edges back.
  logic [W-1:0] hist [2];
  logic [W-1:0] db_m, rise_m, fall_m;
  int           ticks_m [W];
  int           n;
  bit           tick_m;

  task automatic model_edge(input logic rv, input logic [W-1:0] sv);
    logic [W-1:0] seen, new_db;
    bit           tk;
    if (!rv) begin
      hist[0] = '0; hist[1] = '0;
      db_m = '0; rise_m = '0; fall_m = '0;
      for (int i = 0; i < W; i++) ticks_m[i] = 0;
      n = 0;
    end else begin
      tk     = (n % PER) == PER - 1;
      seen   = hist[1];
      new_db = db_m;
      for (int i = 0; i < W; i++) begin
        if (seen[i] == db_m[i]) ticks_m[i] = 0;
        else if (tk) begin
          ticks_m[i] = ticks_m[i] + 1;
          if (ticks_m[i] == ST) begin
            new_db[i]  = seen[i];
            ticks_m[i] = 0;
          end
        end
      end
      rise_m  = new_db & ~db_m;
      fall_m  = db_m & ~new_db;
      db_m    = new_db;
      hist[1] = hist[0];
      hist[0] = sv;
      n++;
    end
    tick_m = (n % PER) == PER - 1;
  endtask

  // Directed-scenario statistics from observed DUT outputs.
  int           rise_cycles, fall_cycles, rise_edge;
  logic [W-1:0] rise_val;
  int           rise_n [W];
  int           fall_n [W];

  task automatic clear_stats();
    rise_cycles = 0; fall_cycles = 0; rise_edge = -1; rise_val = '0;
    for (int i = 0; i < W; i++) begin rise_n[i] = 0; fall_n[i] = 0; end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(rst_n, sw);
    #1;
    check("db",   sw_db,   db_m);
    check("rise", sw_rise, rise_m);
    check("fall", sw_fall, fall_m);
    check("tick", tick,    tick_m);
    if ((sw_rise & sw_fall) != '0) check("rise_fall_excl", sw_rise & sw_fall, 0);
    if (sw_rise != '0) begin
      rise_cycles++;
      if (rise_edge < 0) begin rise_edge = n - 1; rise_val = sw_rise; end
    end
    if (sw_fall != '0) fall_cycles++;
    for (int i = 0; i < W; i++) begin
      rise_n[i] += sw_rise[i];
      fall_n[i] += sw_fall[i];
    end
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  int rem [W];

  initial begin
    clear_stats();
    // Reset and idle: no strobes, tick observed before edges 3, 7, 11.
    sw = '0;
    do_reset();
    check("reset_db", sw_db, 0);
    check("reset_tick", tick, 0);
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (n - 1 == 2 || n - 1 == 6 || n - 1 == 10) check("tick_before_edge", tick, 1);
    end
    check("idle_rise", rise_cycles, 0);
    check("idle_fall", fall_cycles, 0);

    // Step on channel 0 at cycle 20.
    do_reset();
    clear_stats();
    run(20);
    sw = 8'h01;
    run(20);
    check("step_rise_in_window", (rise_edge >= 31 && rise_edge <= 34), 1);
    check("step_rise_val", rise_val, 8'h01);
    check("step_rise_once", rise_cycles, 1);
    check("step_db", sw_db, 8'h01);

    // 6-cycle low glitch is filtered out.
    clear_stats();
    sw = 8'h00;
    run(6);
    sw = 8'h01;
    run(30);
    check("glitch_no_fall", fall_cycles, 0);
    check("glitch_db", sw_db, 8'h01);

    // Multi-channel simultaneous step.
    sw = 8'h00;
    run(20);
    check("clear_db", sw_db, 8'h00);
    clear_stats();
    sw = 8'hA5;
    run(20);
    check("multi_rise_once", rise_cycles, 1);
    check("multi_rise_val", rise_val, 8'hA5);
    check("multi_db", sw_db, 8'hA5);

    // Reset in the middle of filtering.
    sw = 8'hFF;
    run(6);
    do_reset();
    check("midreset_db", sw_db, 8'h00);
    clear_stats();
    run(20);
    check("midreset_rise_window", (rise_edge >= 11 && rise_edge <= 14), 1);
    check("midreset_rise_val", rise_val, 8'hFF);
    check("midreset_rise_once", rise_cycles, 1);

    // Random 1-3 cycle bounce, then settle high.
    sw = 8'h00;
    do_reset();
    run(20);
    clear_stats();
    for (int i = 0; i < W; i++) rem[i] = 0;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < W; i++) begin
        if (rem[i] == 0) begin
          sw[i]  = ~sw[i];
          rem[i] = $urandom_range(1, 3);
        end
        rem[i]--;
      end
      cycle();
    end
    sw = 8'hFF;
    run(30);
    for (int i = 0; i < W; i++) begin
      check($sformatf("bounce_rise_ch%0d", i), rise_n[i], 1);
      check($sformatf("bounce_fall_ch%0d", i), fall_n[i], 0);
    end
    check("bounce_db", sw_db, 8'hFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
